// File: rtl/dvp_capture_ctrl_if.sv
// DVP capture control bus: sensor timing, capture commands and frame status.
// The slave modport is the sequencer side; master is the driver/observer side.
interface dvp_capture_ctrl_if;
  logic        vsync;
  logic        href;
  logic        pix_valid;
  logic        cmd_start;
  logic        cmd_cont;
  logic        cmd_stop;
  logic        cap_en;
  logic        busy;
  logic        frame_start;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  modport slave (
    input  vsync, href, pix_valid, cmd_start, cmd_cont, cmd_stop,
    output cap_en, busy, frame_start, frame_done, frame_err, frame_cnt, err_cnt
  );

  modport master (
    output vsync, href, pix_valid, cmd_start, cmd_cont, cmd_stop,
    input  cap_en, busy, frame_start, frame_done, frame_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/dvp_capture_ctrl.sv
// Frame-level sequencer for the DVP capture datapath (pclk domain).
// Arms on cmd_start, discards SKIP_FRAMES settling frames, then gates the
// datapath per frame (one-shot or continuous), checking line/pixel geometry
// and a vsync-to-vsync timeout.
// Optional build macro: DVP_CAP_STATS_EN enables the saturating err_cnt;
// without it err_cnt is tied to zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | not armed, datapath gated off
// SYNC    | armed, waiting for frame boundary, skipping settling frames
// CAPTURE | datapath enabled, counting lines/pixels of the current frame
module dvp_capture_ctrl #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int SKIP_FRAMES = 2,
  parameter int TIMEOUT_CYC = 2**22
) (
  input  logic                pclk,
  input  logic                rst_n,
  dvp_capture_ctrl_if.slave   bus
);

  localparam int PW = $clog2(WIDTH + 2);
  localparam int LW = $clog2(HEIGHT + 2);
  localparam int SW = $clog2(SKIP_FRAMES + 2);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [PW-1:0] PIX_EXP  = PW'(WIDTH);
  localparam logic [PW-1:0] PIX_MAX  = PW'(WIDTH + 1);
  localparam logic [LW-1:0] LINE_EXP = LW'(HEIGHT);
  localparam logic [LW-1:0] LINE_MAX = LW'(HEIGHT + 1);
  localparam logic [SW-1:0] SKIP_LD  = SW'(SKIP_FRAMES);
  // Down-counter reload: terminal count 0 is reached TIMEOUT_CYC cycles later.
  localparam logic [TW-1:0] TMO_LD   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state;
  logic          vsync_q;
  logic          href_q;
  logic          cont;
  logic          stop_pend;
  logic          bad;
  logic [SW-1:0] skip_cnt;
  logic [LW-1:0] line_cnt;
  logic [PW-1:0] pix_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          cap_en_r;
  logic          busy_r;
  logic          frame_start_r;
  logic          frame_done_r;
  logic          frame_err_r;
  logic [15:0]   frame_cnt_r;

  logic          vs_rise;
  logic          hr_rise;
  logic          line_bad;
  logic          frame_bad;
  logic          tmo_hit;

  // Edge detects and per-frame verdict derived from current counters.
  always_comb begin
    vs_rise   = bus.vsync & ~vsync_q;
    hr_rise   = bus.href & ~href_q;
    line_bad  = (pix_cnt != PIX_EXP);
    frame_bad = bad | line_bad | (line_cnt != LINE_EXP);
    tmo_hit   = (tmo_cnt == '0);
  end

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      cont          <= 1'b0;
      stop_pend     <= 1'b0;
      bad           <= 1'b0;
      skip_cnt      <= '0;
      line_cnt      <= '0;
      pix_cnt       <= '0;
      tmo_cnt       <= '0;
      cap_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_cnt_r   <= '0;
    end else begin
      vsync_q       <= bus.vsync;
      href_q        <= bus.href;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;

      case (state)
        IDLE: begin
          cap_en_r  <= 1'b0;
          busy_r    <= 1'b0;
          stop_pend <= 1'b0;
          // A simultaneous stop cancels the start.
          if (bus.cmd_start && !bus.cmd_stop) begin
            state    <= SYNC;
            busy_r   <= 1'b1;
            cont     <= bus.cmd_cont;
            skip_cnt <= SKIP_LD;
            tmo_cnt  <= TMO_LD;
          end
        end

        SYNC: begin
          if (bus.cmd_stop) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (vs_rise) begin
            tmo_cnt <= TMO_LD;
            if (skip_cnt != '0) begin
              skip_cnt <= skip_cnt - SW'(1);
            end else begin
              state         <= CAPTURE;
              cap_en_r      <= 1'b1;
              frame_start_r <= 1'b1;
              line_cnt      <= '0;
              pix_cnt       <= '0;
              bad           <= 1'b0;
            end
          end else if (tmo_hit) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end

        CAPTURE: begin
          if (bus.cmd_stop) stop_pend <= 1'b1;
          if (vs_rise) begin
            tmo_cnt      <= TMO_LD;
            frame_done_r <= 1'b1;
            if (frame_bad) frame_err_r <= 1'b1;
            else           frame_cnt_r <= frame_cnt_r + 16'd1;
            line_cnt <= '0;
            pix_cnt  <= '0;
            bad      <= 1'b0;
            // A stop arriving on the boundary cycle also ends the run here.
            if (cont && !stop_pend && !bus.cmd_stop) begin
              frame_start_r <= 1'b1;
            end else begin
              state    <= IDLE;
              cap_en_r <= 1'b0;
              busy_r   <= 1'b0;
            end
          end else if (tmo_hit) begin
            state       <= IDLE;
            cap_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
            if (hr_rise) begin
              if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LW'(1);
              // The first href only opens line 1; later ones close the previous line.
              if (line_cnt != '0 && line_bad) bad <= 1'b1;
              // A pixel on the href edge belongs to the new line.
              pix_cnt <= PW'(bus.pix_valid);
            end else if (bus.pix_valid && pix_cnt != PIX_MAX) begin
              pix_cnt <= pix_cnt + PW'(1);
            end
          end
        end

        default: begin
          state    <= IDLE;
          cap_en_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DVP_CAP_STATS_EN
  logic       start_acc;
  logic [7:0] err_cnt_r;

  always_comb begin
    start_acc = (state == IDLE) & bus.cmd_start & ~bus.cmd_stop;
  end

  // Errored-frame statistics: saturating, restarted with each accepted start.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (start_acc) begin
      err_cnt_r <= '0;
    end else if (frame_err_r && err_cnt_r != 8'hff) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_r;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.cap_en      = cap_en_r;
  assign bus.busy        = busy_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl with an 8x4 frame, one skipped frame
// and a 4096-cycle vsync timeout.
module tb_dvp_capture_ctrl;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int TMO = 4096;

  logic pclk;
  logic rst_n;
  int   total;
  int   bad_cnt;
  int   n_done;
  int   n_err;

  dvp_capture_ctrl_if bus ();

  dvp_capture_ctrl #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .SKIP_FRAMES(1),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge pclk) begin
    if (bus.frame_done) n_done++;
    if (bus.frame_err)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.vsync     = 1'b0;
    bus.href      = 1'b0;
    bus.pix_valid = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_cont  = 1'b0;
    bus.cmd_stop  = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    n_done = 0;
    n_err  = 0;
  endtask

  task automatic start(input logic cont);
    bus.cmd_cont  = cont;
    bus.cmd_start = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.cmd_stop = 1'b1;
    cyc(1);
    bus.cmd_stop = 1'b0;
  endtask

  // vsync rise, then check the pulses registered on the following edge.
  task automatic vs_chk(input string tag, input logic s, input logic d, input logic e);
    bus.vsync = 1'b1;
    cyc(1);
    chk({tag, ".start"}, bus.frame_start, s);
    chk({tag, ".done"},  bus.frame_done,  d);
    chk({tag, ".err"},   bus.frame_err,   e);
    cyc(2);
    bus.vsync = 1'b0;
    cyc(2);
  endtask

  task automatic send_line(input int npix);
    bus.href = 1'b1;
    cyc(1);
    for (int p = 0; p < npix; p++) begin
      bus.pix_valid = 1'b1;
      cyc(1);
      bus.pix_valid = 1'b0;
      cyc(1);
    end
    bus.href = 1'b0;
    cyc(2);
  endtask

  // nlines lines of W pixels, except line short_ln (1-based) carries short_pix.
  task automatic send_frame(input int nlines, input int short_ln, input int short_pix);
    for (int l = 1; l <= nlines; l++)
      send_line((l == short_ln) ? short_pix : W);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    total   = 0;
    bad_cnt = 0;

    // Reset state
    do_reset();
    chk("rst.cap_en", bus.cap_en, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.frame_cnt", bus.frame_cnt, 0);
    chk("rst.err_cnt", bus.err_cnt, 0);
    chk("rst.pulses", {bus.frame_start, bus.frame_done, bus.frame_err}, 0);

    // Single good frame, first frame skipped
    start(1'b0);
    chk("single.busy", bus.busy, 1);
    chk("single.cap_en_sync", bus.cap_en, 0);
    vs_chk("single.vs1", 0, 0, 0);
    send_frame(H, 0, 0);
    vs_chk("single.vs2", 1, 0, 0);
    chk("single.cap_en", bus.cap_en, 1);
    send_frame(H, 0, 0);
    vs_chk("single.vs3", 0, 1, 0);
    chk("single.frame_cnt", bus.frame_cnt, 1);
    chk("single.cap_en_end", bus.cap_en, 0);
    chk("single.busy_end", bus.busy, 0);

    // Continuous: three good frames, stop during the fourth
    do_reset();
    start(1'b1);
    vs_chk("cont.vs1", 0, 0, 0);
    send_frame(H, 0, 0);
    vs_chk("cont.vs2", 1, 0, 0);
    send_frame(H, 0, 0);
    vs_chk("cont.vs3", 1, 1, 0);
    send_frame(H, 0, 0);
    vs_chk("cont.vs4", 1, 1, 0);
    send_frame(H, 0, 0);
    vs_chk("cont.vs5", 1, 1, 0);
    chk("cont.frame_cnt3", bus.frame_cnt, 3);
    send_frame(2, 0, 0);
    stop_pulse();
    chk("cont.busy_pend", bus.busy, 1);
    send_frame(2, 0, 0);
    vs_chk("cont.vs6", 0, 1, 0);
    chk("cont.frame_cnt4", bus.frame_cnt, 4);
    chk("cont.busy_end", bus.busy, 0);

    // Geometry errors in continuous mode
    do_reset();
    start(1'b1);
    vs_chk("geo.vs1", 0, 0, 0);
    send_frame(H, 0, 0);
    vs_chk("geo.vs2", 1, 0, 0);
    send_frame(H, 2, W - 1);
    vs_chk("geo.short_pix", 1, 1, 1);
    chk("geo.cnt_a", bus.frame_cnt, 0);
    send_frame(H + 1, 0, 0);
    vs_chk("geo.extra_line", 1, 1, 1);
    chk("geo.cnt_b", bus.frame_cnt, 0);
`ifdef DVP_CAP_STATS_EN
    chk("geo.err_cnt", bus.err_cnt, 2);
`else
    chk("geo.err_cnt", bus.err_cnt, 0);
`endif
    send_frame(H, 0, 0);
    vs_chk("geo.good", 1, 1, 0);
    chk("geo.cnt_c", bus.frame_cnt, 1);

    // Timeout with vsync held low
    do_reset();
    start(1'b0);
    n = 0;
    for (int i = 1; i <= TMO + 200; i++) begin
      cyc(1);
      if (bus.frame_err) begin
        n = i;
        break;
      end
    end
    chk("tmo.cycles", n, TMO);
    chk("tmo.done_cnt", n_done, 0);
    chk("tmo.busy", bus.busy, 0);
    chk("tmo.frame_cnt", bus.frame_cnt, 0);
    cyc(1);
    chk("tmo.err_pulses", n_err, 1);

    // Corner commands
    do_reset();
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    chk("corner.start_stop", bus.busy, 0);
    start(1'b0);
    chk("corner.sync_busy", bus.busy, 1);
    stop_pulse();
    chk("corner.sync_stop", bus.busy, 0);

    start(1'b1);
    vs_chk("corner.vs1", 0, 0, 0);
    vs_chk("corner.vs2", 1, 0, 0);
    send_line(3);
    chk("corner.cap_en_pre", bus.cap_en, 1);
    bus.pix_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    chk("corner.rst_outs",
        {bus.cap_en, bus.busy, bus.frame_start, bus.frame_done, bus.frame_err}, 0);
    chk("corner.rst_cnt", bus.frame_cnt, 0);
    cyc(3);
    chk("corner.rst_hold", {bus.cap_en, bus.busy, bus.frame_done, bus.frame_err}, 0);
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end
endmodule
